// File: rtl/ofs_plat_host_mem_rd_arbiter.sv
// Round-robin arbiter merging per-port host-memory reads onto one request channel,
// routing tagged responses back by port id, with per-port in-flight caps and a drain handshake.
module ofs_plat_host_mem_rd_arbiter #(
   parameter int unsigned NUM_PORTS       = 2,
   parameter int unsigned ADDR_W          = 42,
   parameter int unsigned MAX_OUTSTANDING = 64,
   parameter int unsigned DATA_W          = 512
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_PORTS-1:0]        req_valid,
   input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
   input  logic [NUM_PORTS*12-1:0]     req_mdata,
   output logic [NUM_PORTS-1:0]        req_ready,
   output logic                        c0tx_valid,
   output logic [ADDR_W-1:0]           c0tx_addr,
   output logic [15:0]                 c0tx_mdata,
   input  logic                        c0tx_almfull,
   input  logic                        c0rx_valid,
   input  logic [15:0]                 c0rx_mdata,
   input  logic [DATA_W-1:0]           c0rx_data,
   output logic [NUM_PORTS-1:0]        rsp_valid,
   output logic [11:0]                 rsp_mdata,
   output logic [DATA_W-1:0]           rsp_data,
   input  logic                        drain_req,
   output logic                        drain_done,
   output logic                        err_sticky
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned PTR_W = $clog2(NUM_PORTS);
   localparam int unsigned TAG_W = 12;
   localparam int unsigned PID_W = 4;

   typedef enum logic [1:0] {ST_RUN, ST_DRAINING, ST_DRAINED} state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic                    w_drain_done_next;
   logic [PTR_W-1:0]        r_rr_ptr;
   logic [PTR_W-1:0]        w_win;
   logic                    w_found;
   logic                    w_accept;
   logic                    w_idle;
   logic [NUM_PORTS-1:0]    w_ready;
   logic [NUM_PORTS-1:0]    w_inc;
   logic [NUM_PORTS-1:0]    w_elig;
   logic [NUM_PORTS-1:0]    w_zero;
   logic                    w_all_zero;
   logic [CNT_W-1:0]        r_outstanding [NUM_PORTS];
   logic [ADDR_W-1:0]       w_win_addr;
   logic [15:0]             w_win_mdata;
   logic [PID_W-1:0]        w_rsp_port;
   logic                    w_rsp_in_range;
   logic [NUM_PORTS-1:0]    w_rsp_hit;
   logic                    w_rsp_underflow;
   logic                    r_c0tx_valid;
   logic [ADDR_W-1:0]       r_c0tx_addr;
   logic [15:0]             r_c0tx_mdata;
   logic [NUM_PORTS-1:0]    r_rsp_valid;
   logic [TAG_W-1:0]        r_rsp_mdata;
   logic [DATA_W-1:0]       r_rsp_data;
   logic                    r_drain_done;
   logic                    r_err_sticky;

   // Per-port credit status
   always_comb begin
      w_elig = '0;
      w_zero = '0;
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
         w_elig[p] = r_outstanding[p] < CNT_W'(MAX_OUTSTANDING);
         w_zero[p] = r_outstanding[p] == '0;
      end
   end

   assign w_all_zero = &w_zero;

   // Round-robin search starting at r_rr_ptr
   always_comb begin
      int v_idx;
      w_found = 1'b0;
      w_win   = '0;
      v_idx   = 0;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         v_idx = (int'(r_rr_ptr) + i) % int'(NUM_PORTS);
         if (!w_found && req_valid[PTR_W'(v_idx)] && w_elig[PTR_W'(v_idx)]) begin
            w_found = 1'b1;
            w_win   = PTR_W'(v_idx);
         end
      end
   end

   always_comb begin
      w_ready = '0;
      if (reset_n && (r_state == ST_RUN) && !c0tx_almfull && w_found) begin
         w_ready[w_win] = 1'b1;
      end
   end

   assign req_ready   = w_ready;
   assign w_inc       = req_valid & w_ready;
   assign w_accept    = |w_inc;
   assign w_win_addr  = req_addr[32'(w_win)*ADDR_W +: ADDR_W];
   assign w_win_mdata = {PID_W'(w_win), req_mdata[32'(w_win)*TAG_W +: TAG_W]};

   // Response decode: out-of-range port ids are dropped
   assign w_rsp_port     = c0rx_mdata[15:12];
   assign w_rsp_in_range = 32'(w_rsp_port) < NUM_PORTS;

   always_comb begin
      w_rsp_hit = '0;
      if (c0rx_valid && w_rsp_in_range) begin
         w_rsp_hit[PTR_W'(w_rsp_port)] = 1'b1;
      end
   end

   assign w_rsp_underflow = |(w_rsp_hit & w_zero);
   assign w_idle          = w_all_zero && !r_c0tx_valid && !w_accept;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_drain_done_next = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (drain_req) w_state_next = w_idle ? ST_DRAINED : ST_DRAINING;
         end
         ST_DRAINING: begin
            if (!drain_req)  w_state_next = ST_RUN;
            else if (w_idle) w_state_next = ST_DRAINED;
         end
         ST_DRAINED: begin
            if (!drain_req) w_state_next = ST_RUN;
         end
         default: w_state_next = ST_RUN;
      endcase
      w_drain_done_next = (w_state_next == ST_DRAINED);
   end

   // Request path, pointer, status flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_c0tx_valid <= 1'b0;
         r_c0tx_addr  <= '0;
         r_c0tx_mdata <= '0;
         r_rr_ptr     <= '0;
         r_drain_done <= 1'b0;
         r_err_sticky <= 1'b0;
      end else begin
         r_c0tx_valid <= w_accept;
         if (w_accept) begin
            r_c0tx_addr  <= w_win_addr;
            r_c0tx_mdata <= w_win_mdata;
            r_rr_ptr     <= (32'(w_win) == NUM_PORTS - 1) ? '0 : w_win + PTR_W'(1);
         end
         r_drain_done <= w_drain_done_next;
         if (c0rx_valid && (!w_rsp_in_range || w_rsp_underflow)) begin
            r_err_sticky <= 1'b1;
         end
      end
   end

   // Response path
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rsp_valid <= '0;
         r_rsp_mdata <= '0;
         r_rsp_data  <= '0;
      end else begin
         r_rsp_valid <= w_rsp_hit;
         if (c0rx_valid) begin
            r_rsp_mdata <= c0rx_mdata[11:0];
            r_rsp_data  <= c0rx_data;
         end
      end
   end

   // In-flight counters; simultaneous accept and response cancel, underflow saturates at zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p < int'(NUM_PORTS); p++) r_outstanding[p] <= '0;
      end else begin
         for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (w_inc[p] && !w_rsp_hit[p]) begin
               r_outstanding[p] <= r_outstanding[p] + CNT_W'(1);
            end else if (!w_inc[p] && w_rsp_hit[p] && !w_zero[p]) begin
               r_outstanding[p] <= r_outstanding[p] - CNT_W'(1);
            end
         end
      end
   end

   assign c0tx_valid = r_c0tx_valid;
   assign c0tx_addr  = r_c0tx_addr;
   assign c0tx_mdata = r_c0tx_mdata;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_mdata  = r_rsp_mdata;
   assign rsp_data   = r_rsp_data;
   assign drain_done = r_drain_done;
   assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_ofs_plat_host_mem_rd_arbiter.sv
// Scoreboard bench for ofs_plat_host_mem_rd_arbiter: expected requests/responses are queued
// when driven and compared when the DUT emits them.
module tb_ofs_plat_host_mem_rd_arbiter;

   localparam int unsigned NP = 2;
   localparam int unsigned AW = 42;
   localparam int unsigned DW = 64;
   localparam int unsigned MO = 64;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [NP-1:0]       req_valid;
   logic [NP*AW-1:0]    req_addr;
   logic [NP*12-1:0]    req_mdata;
   logic [NP-1:0]       req_ready;
   logic                c0tx_valid;
   logic [AW-1:0]       c0tx_addr;
   logic [15:0]         c0tx_mdata;
   logic                c0tx_almfull;
   logic                c0rx_valid;
   logic [15:0]         c0rx_mdata;
   logic [DW-1:0]       c0rx_data;
   logic [NP-1:0]       rsp_valid;
   logic [11:0]         rsp_mdata;
   logic [DW-1:0]       rsp_data;
   logic                drain_req;
   logic                drain_done;
   logic                err_sticky;

   typedef struct {
      int          due;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] c;
   } exp_t;

   exp_t txq[$];
   exp_t rsq[$];
   exp_t m_e;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   ofs_plat_host_mem_rd_arbiter #(
      .NUM_PORTS(NP), .ADDR_W(AW), .MAX_OUTSTANDING(MO), .DATA_W(DW)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_addr(req_addr), .req_mdata(req_mdata), .req_ready(req_ready),
      .c0tx_valid(c0tx_valid), .c0tx_addr(c0tx_addr), .c0tx_mdata(c0tx_mdata),
      .c0tx_almfull(c0tx_almfull),
      .c0rx_valid(c0rx_valid), .c0rx_mdata(c0rx_mdata), .c0rx_data(c0rx_data),
      .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_data(rsp_data),
      .drain_req(drain_req), .drain_done(drain_done), .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One cycle of stimulus; exp_port is the port the bench expects to be granted (-1 = none)
   task automatic drive(input logic [NP-1:0] vmask, input int exp_port, input logic almf,
                        input logic drn, input logic rxv, input logic [15:0] rxm);
      exp_t          e;
      logic [NP-1:0] exp_rdy;
      @(negedge clk);
      req_valid    = vmask;
      c0tx_almfull = almf;
      drain_req    = drn;
      for (int p = 0; p < int'(NP); p++) begin
         req_addr[p*AW +: AW]  = AW'({$urandom(), $urandom()});
         req_mdata[p*12 +: 12] = 12'($urandom());
      end
      c0rx_valid = rxv;
      c0rx_mdata = rxm;
      c0rx_data  = {$urandom(), $urandom()};
      if (rxv && (32'(rxm[15:12]) < NP)) begin
         e.due = cyc + 1;
         e.a   = 64'(1) << rxm[15:12];
         e.b   = 64'(rxm[11:0]);
         e.c   = 64'(c0rx_data);
         rsq.push_back(e);
      end
      #1;
      exp_rdy = (exp_port >= 0) ? (NP'(1) << exp_port) : '0;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (exp_port >= 0) begin
         e.due = cyc + 1;
         e.a   = 64'(req_addr[exp_port*AW +: AW]);
         e.b   = 64'({4'(exp_port), req_mdata[exp_port*12 +: 12]});
         e.c   = '0;
         txq.push_back(e);
      end
   endtask

   task automatic req(input logic [NP-1:0] vmask, input int exp_port);
      drive(vmask, exp_port, 1'b0, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic rx(input logic [3:0] port);
      drive('0, -1, 1'b0, 1'b0, 1'b1, {port, 12'($urandom())});
   endtask

   // Output monitor: compares against queued expectations
   always @(negedge clk) begin
      if (reset_n) begin
         while (txq.size() > 0 && txq[0].due < cyc) begin
            m_e = txq.pop_front();
            chk("c0tx_late", 64'(cyc), 64'(m_e.due));
         end
         if (txq.size() > 0 && txq[0].due == cyc) begin
            m_e = txq.pop_front();
            chk("c0tx_valid", 64'(c0tx_valid), 64'(1));
            chk("c0tx_addr", 64'(c0tx_addr), m_e.a);
            chk("c0tx_mdata", 64'(c0tx_mdata), m_e.b);
         end else if (c0tx_valid) begin
            chk("c0tx_spurious", 64'(c0tx_valid), 64'(0));
         end
         while (rsq.size() > 0 && rsq[0].due < cyc) begin
            m_e = rsq.pop_front();
            chk("rsp_late", 64'(cyc), 64'(m_e.due));
         end
         if (rsq.size() > 0 && rsq[0].due == cyc) begin
            m_e = rsq.pop_front();
            chk("rsp_valid", 64'(rsp_valid), m_e.a);
            chk("rsp_mdata", 64'(rsp_mdata), m_e.b);
            chk("rsp_data", 64'(rsp_data), m_e.c);
         end else if (rsp_valid != '0) begin
            chk("rsp_spurious", 64'(rsp_valid), 64'(0));
         end
      end
   end

   initial begin
      reset_n      = 1'b0;
      req_valid    = '1;
      req_addr     = '0;
      req_mdata    = '0;
      c0tx_almfull = 1'b0;
      c0rx_valid   = 1'b0;
      c0rx_mdata   = '0;
      c0rx_data    = '0;
      drain_req    = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_c0tx_valid", 64'(c0tx_valid), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_drain_done", 64'(drain_done), 64'(0));
      chk("rst_err", 64'(err_sticky), 64'(0));
      req_valid = '0;
      reset_n   = 1'b1;

      // Alternating grants with both ports requesting
      req(2'b11, 0);
      req(2'b11, 1);
      req(2'b11, 0);
      req(2'b11, 1);
      req(2'b00, -1);
      @(negedge clk);
      chk("c0tx_idle", 64'(c0tx_valid), 64'(0));
      rx(4'd0);
      rx(4'd0);
      rx(4'd1);
      rx(4'd1);

      // Almost-full blocks all accepts and holds the pointer
      for (int i = 0; i < 5; i++) drive(2'b11, -1, 1'b1, 1'b0, 1'b0, 16'h0);
      chk("almfull_c0tx", 64'(c0tx_valid), 64'(0));
      req(2'b11, 0);
      req(2'b11, 1);

      // Port 1 up to 3 in flight, then accept+response in the same cycle
      req(2'b10, 1);
      req(2'b10, 1);
      drive(2'b10, 1, 1'b0, 1'b0, 1'b1, {4'd1, 12'h3a5});
      rx(4'd0);
      rx(4'd1);

      // Drain with two reads outstanding on port 1
      drive(2'b00, -1, 1'b0, 1'b1, 1'b0, 16'h0);
      drive(2'b11, -1, 1'b0, 1'b1, 1'b1, {4'd1, 12'h111});
      chk("drain_busy0", 64'(drain_done), 64'(0));
      drive(2'b11, -1, 1'b0, 1'b1, 1'b1, {4'd1, 12'h222});
      chk("drain_busy1", 64'(drain_done), 64'(0));
      drive(2'b11, -1, 1'b0, 1'b1, 1'b0, 16'h0);
      chk("drain_busy2", 64'(drain_done), 64'(0));
      drive(2'b11, -1, 1'b0, 1'b1, 1'b0, 16'h0);
      chk("drain_done_rise", 64'(drain_done), 64'(1));
      drive(2'b11, -1, 1'b0, 1'b0, 1'b0, 16'h0);
      chk("drain_done_hold", 64'(drain_done), 64'(1));
      drive(2'b11, 0, 1'b0, 1'b0, 1'b0, 16'h0);
      chk("drain_done_fall", 64'(drain_done), 64'(0));
      rx(4'd0);

      // Per-port cap: port 0 fills, port 1 still granted, one response reopens port 0
      for (int i = 0; i < int'(MO); i++) req(2'b01, 0);
      req(2'b11, 1);
      drive(2'b01, -1, 1'b0, 1'b0, 1'b1, {4'd0, 12'h0ab});
      req(2'b01, 0);
      for (int i = 0; i < int'(MO); i++) rx(4'd0);
      rx(4'd1);

      // Drain while already idle goes straight to drained
      drive(2'b00, -1, 1'b0, 1'b1, 1'b0, 16'h0);
      drive(2'b00, -1, 1'b0, 1'b0, 1'b0, 16'h0);
      chk("idle_drain_done", 64'(drain_done), 64'(1));
      drive(2'b00, -1, 1'b0, 1'b0, 1'b0, 16'h0);
      chk("idle_drain_clear", 64'(drain_done), 64'(0));

      // Out-of-range port id: dropped, sticky error until reset
      chk("err_clean", 64'(err_sticky), 64'(0));
      drive(2'b00, -1, 1'b0, 1'b0, 1'b1, 16'hF005);
      req(2'b00, -1);
      chk("bad_port_rsp", 64'(rsp_valid), 64'(0));
      chk("bad_port_err", 64'(err_sticky), 64'(1));
      repeat (3) req(2'b00, -1);
      chk("err_sticky_hold", 64'(err_sticky), 64'(1));
      req(2'b01, 0);
      req(2'b00, -1);

      // Mid-run reset, then a response for a request issued before it
      @(negedge clk);
      req_valid = '1;
      reset_n   = 1'b0;
      #1;
      chk("mid_rst_ready", 64'(req_ready), 64'(0));
      chk("mid_rst_err", 64'(err_sticky), 64'(0));
      chk("mid_rst_done", 64'(drain_done), 64'(0));
      chk("mid_rst_c0tx", 64'(c0tx_valid), 64'(0));
      @(negedge clk);
      req_valid = '0;
      reset_n   = 1'b1;
      rx(4'd0);
      req(2'b00, -1);
      chk("underflow_err", 64'(err_sticky), 64'(1));
      req(2'b11, 0);
      req(2'b00, -1);
      req(2'b00, -1);

      chk("txq_empty", 64'(txq.size()), 64'(0));
      chk("rsq_empty", 64'(rsq.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
